// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB control FSM for the RV32I subset the 32-bit ALU datapath supports.
// Latches the fetched instruction and drives ALU opcode, datapath and memory strobes.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        load_pc,
  output logic        pc_src,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSrl = 4'b1000;
  localparam logic [3:0] AluSll = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1010;
  localparam logic [3:0] AluXor = 4'b1101;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  wcnt_q, wcnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_alu, is_lw, is_sw, is_beq, rd_nonzero;
  logic [3:0] dec_op;
  logic       dec_src;
  logic       unused_ir;

  assign opcode     = ir_q[6:0];
  assign funct3     = ir_q[14:12];
  assign rd_nonzero = |ir_q[11:7];
  assign unused_ir  = ^{ir_q[31], ir_q[29:15]};

  // Instruction decode; anything not recognised falls through as a NOP-like ADD.
  always_comb begin
    is_alu  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    dec_op  = AluAdd;
    dec_src = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011: begin
        if (funct3 != 3'b011) begin
          is_alu  = 1'b1;
          // opcode[5] separates R-type (register op2) from I-ALU (immediate op2)
          dec_src = ~opcode[5];
          case (funct3)
            3'b000:  dec_op = (opcode[5] && ir_q[30]) ? AluSub : AluAdd;
            3'b001:  dec_op = AluSll;
            3'b010:  dec_op = AluSlt;
            3'b100:  dec_op = AluXor;
            3'b101:  dec_op = ir_q[30] ? AluSra : AluSrl;
            3'b110:  dec_op = AluOr;
            3'b111:  dec_op = AluAnd;
            default: dec_op = AluAdd;
          endcase
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          is_lw   = 1'b1;
          dec_src = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          is_sw   = 1'b1;
          dec_src = 1'b1;
        end
      end
      7'b1100011: begin
        if (funct3 == 3'b000) begin
          is_beq = 1'b1;
          dec_op = AluSub;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    wcnt_d     = wcnt_q;
    alu_op     = AluAdd;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    load_pc    = 1'b0;
    pc_src     = 1'b0;
    unique case (state_q)
      StIf: begin
        ir_d    = instr;
        state_d = StId;
      end
      StId: state_d = StEx;
      StEx: begin
        alu_op  = dec_op;
        alu_src = dec_src;
        if (is_beq) begin
          load_pc = 1'b1;
          pc_src  = zero;
          state_d = StIf;
        end else begin
          state_d = StMem;
        end
      end
      StMem: begin
        alu_op    = dec_op;
        alu_src   = dec_src;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (32'(wcnt_q) < MEM_WAIT) begin
          wcnt_d = wcnt_q + 4'd1;
        end else begin
          wcnt_d  = 4'd0;
          state_d = StWb;
        end
      end
      StWb: begin
        alu_op     = dec_op;
        alu_src    = dec_src;
        load_pc    = 1'b1;
        reg_write  = (is_alu || is_lw) && rd_nonzero;
        mem_to_reg = is_lw;
        state_d    = StIf;
      end
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIf;
      ir_q    <= 32'd0;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed test-plan instructions plus random instructions and resets,
// compared every cycle against a per-instruction cycle-schedule model.
module tb_multicycle_ctrl;

  localparam int unsigned MW = 2;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] SRA = 4'b1010;
  localparam logic [3:0] NO_LIT = 4'b1111;
  // funct3 -> ALU code for register/immediate ALU ops (index 3 is unused)
  localparam logic [3:0] F3_OP [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b1111,
                                       4'b1101, 4'b1000, 4'b0001, 4'b0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, mem_to_reg, reg_write, load_pc, pc_src;
  logic [2:0]  state;

  multicycle_ctrl #(.MEM_WAIT(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .load_pc    (load_pc),
    .pc_src     (pc_src),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int lp_count, strobe_count;

  logic       exp_valid = 1'b0;
  logic [2:0] e_state;
  logic [3:0] e_op;
  logic       e_src, e_mr, e_mw, e_m2r, e_rw, e_lp, e_ps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
  endtask

  // Spec-level decode: class 0 unsupported, 1 R, 2 I-ALU, 3 LW, 4 SW, 5 BEQ.
  function automatic void model_dec(input logic [31:0] ins, output int cls,
                                    output logic [3:0] op, output logic src);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    cls = 0;
    op  = ADD;
    src = 1'b0;
    if ((opc == 7'h33 || opc == 7'h13) && f3 != 3'b011) begin
      cls = (opc == 7'h33) ? 1 : 2;
      src = (cls == 2);
      op  = F3_OP[f3];
      if (ins[30] && f3 == 3'b101) op = SRA;
      if (ins[30] && f3 == 3'b000 && cls == 1) op = SUB;
    end else if (opc == 7'h03 && f3 == 3'b010) begin
      cls = 3;
      src = 1'b1;
    end else if (opc == 7'h23 && f3 == 3'b010) begin
      cls = 4;
      src = 1'b1;
    end else if (opc == 7'h63 && f3 == 3'b000) begin
      cls = 5;
      op  = SUB;
    end
  endfunction

  task automatic exp_idle(input logic [2:0] st);
    e_state = st;
    e_op    = ADD;
    {e_src, e_mr, e_mw, e_m2r, e_rw, e_lp, e_ps} = '0;
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("state", 32'(state), 32'(e_state));
      check("alu_op", 32'(alu_op), 32'(e_op));
      check("alu_src", 32'(alu_src), 32'(e_src));
      check("mem_read", 32'(mem_read), 32'(e_mr));
      check("mem_write", 32'(mem_write), 32'(e_mw));
      check("mem_to_reg", 32'(mem_to_reg), 32'(e_m2r));
      check("reg_write", 32'(reg_write), 32'(e_rw));
      check("load_pc", 32'(load_pc), 32'(e_lp));
      check("pc_src", 32'(pc_src), 32'(e_ps));
      if (load_pc) lp_count++;
      if (mem_read || mem_write) strobe_count++;
    end
  end

  // One instruction from IF onward; abort_at >= 0 raises rst in that cycle.
  // lit_op/lit_strobes are hand-computed expectations (NO_LIT / -1 to skip).
  task automatic run_instr(input logic [31:0] ins, input logic z, input int abort_at,
                           input logic [3:0] lit_op, input int lit_strobes);
    int cls, n, ph;
    logic [3:0] op;
    logic src;
    model_dec(ins, cls, op, src);
    n = (cls == 5) ? 3 : 5 + int'(MW);
    lp_count = 0;
    strobe_count = 0;
    for (int c = 0; c < n; c++) begin
      rst   = (c == abort_at);
      instr = (c == 0) ? ins : $urandom;
      zero  = (c == 2) ? z : 1'($urandom);
      ph    = (c < 3) ? c : ((c < n - 1) ? 3 : 4);
      exp_idle(3'(ph));
      if (ph >= 2) begin
        e_op  = op;
        e_src = src;
      end
      if (ph == 2 && cls == 5) begin
        e_lp = 1'b1;
        e_ps = z;
      end
      if (ph == 3) begin
        e_mr = (cls == 3);
        e_mw = (cls == 4);
      end
      if (ph == 4) begin
        e_lp  = 1'b1;
        e_rw  = (cls >= 1 && cls <= 3) && (ins[11:7] != 5'd0);
        e_m2r = (cls == 3);
      end
      exp_valid = 1'b1;
      if (c == 2 && lit_op != NO_LIT) begin
        #3 check("lit_alu_op_ex", 32'(alu_op), 32'(lit_op));
        @(posedge clk);
      end else begin
        @(posedge clk);
      end
      #1;
      if (c == abort_at) return;
    end
    check("load_pc_pulses", 32'(lp_count), 32'd1);
    if (lit_strobes >= 0) check("lit_mem_strobe_cycles", 32'(strobe_count), 32'(lit_strobes));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: begin r[6:0] = 7'h03; r[14:12] = 3'b010; end
      3: begin r[6:0] = 7'h23; r[14:12] = 3'b010; end
      4: begin r[6:0] = 7'h63; r[14:12] = 3'b000; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst   = 1'b1;
    instr = 32'h0000_0033;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    exp_idle(3'd0);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;

    run_instr(32'h0000_0033, 1'b0, -1, ADD, 0);
    run_instr(32'h0020_81B3, 1'b0, -1, ADD, 0);
    run_instr(32'h4020_81B3, 1'b1, -1, SUB, 0);
    run_instr(32'h4030_D193, 1'b0, -1, SRA, 0);
    run_instr(32'h0020_A193, 1'b0, -1, 4'b0111, 0);
    run_instr(32'h0040_A183, 1'b0, -1, ADD, 3);
    run_instr(32'h0030_A223, 1'b1, -1, ADD, 3);
    run_instr(32'h0020_8463, 1'b1, -1, SUB, 0);
    run_instr(32'h0020_8463, 1'b0, -1, SUB, 0);
    run_instr(32'h0030_A223, 1'b0, 3, ADD, -1);
    run_instr(32'h0020_B1B3, 1'b1, -1, ADD, 0);
    run_instr(32'h0000_0000, 1'b0, -1, ADD, 0);

    for (int i = 0; i < 300; i++) begin
      int ab;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(rand_instr(), 1'($urandom), ab, NO_LIT, -1);
    end

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
